// File: rtl/conv_frame_ctrl_if.sv
// Frame sequencer bus: host control, frame buffer read port,
// conv layer pixel feed and result strobe.
interface conv_frame_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int PIX_WIDTH  = 24,
    parameter int CNT_WIDTH  = 16
);
    logic                  start;
    logic                  stall;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [PIX_WIDTH-1:0]  mem_rdata;
    logic                  frame_start;
    logic                  pixel_valid;
    logic [PIX_WIDTH-1:0]  pixel_out;
    logic                  conv_valid;
    logic                  busy;
    logic                  done;
    logic                  timeout_err;
    logic [CNT_WIDTH-1:0]  out_count;

    modport master (
        input  start, stall, mem_rdata, conv_valid,
        output mem_rd_en, mem_addr, frame_start, pixel_valid,
        output pixel_out, busy, done, timeout_err, out_count
    );

    modport slave (
        output start, stall, mem_rdata, conv_valid,
        input  mem_rd_en, mem_addr, frame_start, pixel_valid,
        input  pixel_out, busy, done, timeout_err, out_count
    );
endinterface

// File: rtl/conv_frame_ctrl.sv
// Streams one image from the frame buffer into the conv layer
// and counts its results, with a drain timeout.
module conv_frame_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int IN_CHANNEL     = 3,
    parameter int IMG_WIDTH      = 4,
    parameter int IMG_HEIGHT     = 4,
    parameter int KERNEL_SIZE    = 3,
    parameter int STRIDE         = 1,
    parameter int PADDING        = (KERNEL_SIZE - 1) / 2,
    parameter int ADDR_WIDTH     = 4,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic               i_clk,
    input logic               i_rst_n,
    conv_frame_ctrl_if.master io_bus
);
    localparam int PIX_W = IN_CHANNEL * DATA_WIDTH;
    localparam int OUT_W = (IMG_WIDTH + 2 * PADDING - KERNEL_SIZE) / STRIDE + 1;
    localparam int OUT_H = (IMG_HEIGHT + 2 * PADDING - KERNEL_SIZE) / STRIDE + 1;
    localparam int N_OUT = OUT_W * OUT_H;
    localparam int N_PIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int TW    = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_PIX - 1);
    localparam logic [CNT_WIDTH-1:0]  N_OUT_C   = CNT_WIDTH'(N_OUT);
    localparam logic [TW-1:0]         TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic                  r_pix_valid;
    logic                  r_tmo_err;
    logic [CNT_WIDTH-1:0]  r_out_count;
    logic [TW-1:0]         r_tcnt;
    logic                  w_rd_en;
    logic                  w_accept;
    logic                  w_complete;
    logic                  w_tmo_hit;
    logic [PIX_W-1:0]      w_pix;

    assign w_rd_en    = (r_state == S_STREAM) && !io_bus.stall;
    assign w_accept   = (r_state == S_IDLE) && io_bus.start;
    assign w_complete = (r_out_count >= N_OUT_C);
    assign w_tmo_hit  = (r_tcnt == TMO_LAST);
    assign w_pix      = io_bus.mem_rdata;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state decode; completion takes priority over timeout
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (io_bus.start) w_next = S_START;
            S_START:  w_next = S_STREAM;
            S_STREAM: if (w_rd_en && r_rd_ptr == LAST_ADDR) w_next = S_DRAIN;
            S_DRAIN:  if (w_complete || w_tmo_hit) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Read pointer and one-cycle read-latency strobe
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_ptr    <= '0;
            r_pix_valid <= 1'b0;
        end else begin
            r_pix_valid <= w_rd_en;
            if (w_accept)     r_rd_ptr <= '0;
            else if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Saturating result counter, live from START through DONE
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_out_count <= '0;
        end else if (r_state == S_IDLE) begin
            if (io_bus.start) r_out_count <= '0;
        end else if (io_bus.conv_valid && r_out_count != '1) begin
            r_out_count <= r_out_count + 1'b1;
        end
    end

    // Drain watchdog and sticky timeout flag
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tcnt    <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            if (r_state == S_DRAIN) r_tcnt <= r_tcnt + 1'b1;
            else                    r_tcnt <= '0;
            if (w_accept)
                r_tmo_err <= 1'b0;
            else if (r_state == S_DRAIN && !w_complete && w_tmo_hit)
                r_tmo_err <= 1'b1;
        end
    end

    assign io_bus.mem_rd_en   = w_rd_en;
    assign io_bus.mem_addr    = r_rd_ptr;
    assign io_bus.frame_start = (r_state == S_START);
    assign io_bus.pixel_valid = r_pix_valid;
    assign io_bus.pixel_out   = w_pix;
    assign io_bus.busy        = (r_state != S_IDLE);
    assign io_bus.done        = (r_state == S_DONE);
    assign io_bus.timeout_err = r_tmo_err;
    assign io_bus.out_count   = r_out_count;
endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Directed bench for conv_frame_ctrl: frame buffer model, conv
// result model, stall injector and per-frame monitor.
module tb_conv_frame_ctrl;
    logic clk = 1'b0;
    logic rst_n;

    conv_frame_ctrl_if #(.ADDR_WIDTH(4), .PIX_WIDTH(24), .CNT_WIDTH(16)) bus ();

    conv_frame_ctrl dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Monitor state
    int cyc = 0;
    int fs_total = 0;
    int fs_cyc = 0;
    int rd_cnt = 0;
    int addr_bad = 0;
    int rd_first = 0;
    int rd_last = 0;
    int pv_cnt = 0;
    int pv_cyc [16];
    int pix_bad = 0;
    int done_cnt = 0;
    int done_total = 0;
    int done_cyc = 0;
    int conv_sent = 0;
    int arm_cyc = -100;

    // Controls from the stimulus process
    int   conv_limit = 16;
    logic stall_mode = 1'b0;
    logic idle_pulse = 1'b0;

    function automatic logic [23:0] pix(input logic [3:0] a);
        return {4'h1, a, 4'h2, a, 4'h3, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Frame buffer: synchronous read, one cycle latency
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= pix(bus.mem_addr);
    end

    // Stall: high for 3 cycles right after address 5 is issued
    always @(posedge clk) begin
        #2;
        bus.stall = (cyc >= arm_cyc && cyc < arm_cyc + 3);
    end

    // Monitor and conv model (one result per pixel, up to conv_limit)
    always @(negedge clk) begin
        cyc++;
        if (bus.frame_start) begin
            fs_total++;
            fs_cyc = cyc;
            rd_cnt = 0;
            addr_bad = 0;
            pv_cnt = 0;
            pix_bad = 0;
            done_cnt = 0;
            conv_sent = 0;
        end
        if (bus.mem_rd_en) begin
            if (bus.mem_addr !== rd_cnt[3:0]) addr_bad++;
            if (rd_cnt == 0) rd_first = cyc;
            rd_last = cyc;
            if (stall_mode && bus.mem_addr == 4'd5) arm_cyc = cyc;
            rd_cnt++;
        end
        if (bus.pixel_valid) begin
            if (bus.pixel_out !== pix(pv_cnt[3:0])) pix_bad++;
            if (pv_cnt < 16) pv_cyc[pv_cnt] = cyc;
            pv_cnt++;
        end
        if (bus.done) begin
            done_cnt++;
            done_total++;
            done_cyc = cyc;
        end
        if (bus.pixel_valid && conv_sent < conv_limit) begin
            bus.conv_valid = 1'b1;
            conv_sent++;
        end else begin
            bus.conv_valid = idle_pulse;
        end
    end

    task automatic start_frame();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_seen", 64'(got), 64'd1);
    endtask

    int fs0;
    int dt0;

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_pv", 64'(bus.pixel_valid), 64'd0);
        chk("rst_cnt", 64'(bus.out_count), 64'd0);
        chk("rst_tmo", 64'(bus.timeout_err), 64'd0);
        chk("rst_rden", 64'(bus.mem_rd_en), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Frame 1: no stall, 16 results
        fs0 = fs_total;
        start_frame();
        chk("f1_fs", 64'(bus.frame_start), 64'd1);
        chk("f1_busy", 64'(bus.busy), 64'd1);
        wait_done();
        chk("f1_tmo", 64'(bus.timeout_err), 64'd0);
        @(negedge clk);
        chk("f1_idle", 64'(bus.busy), 64'd0);
        chk("f1_fs_cnt", 64'(fs_total - fs0), 64'd1);
        chk("f1_rd_cnt", 64'(rd_cnt), 64'd16);
        chk("f1_addr", 64'(addr_bad), 64'd0);
        chk("f1_rd_span", 64'(rd_last - rd_first), 64'd15);
        chk("f1_pv_cnt", 64'(pv_cnt), 64'd16);
        chk("f1_pv_lat", 64'(pv_cyc[0] - fs_cyc), 64'd2);
        chk("f1_pix", 64'(pix_bad), 64'd0);
        chk("f1_done", 64'(done_cnt), 64'd1);
        chk("f1_count", 64'(bus.out_count), 64'd16);

        // Frame 2: 3-cycle stall after address 5
        stall_mode = 1'b1;
        start_frame();
        wait_done();
        stall_mode = 1'b0;
        @(negedge clk);
        chk("f2_rd_cnt", 64'(rd_cnt), 64'd16);
        chk("f2_addr", 64'(addr_bad), 64'd0);
        chk("f2_rd_span", 64'(rd_last - rd_first), 64'd18);
        chk("f2_pv5", 64'(pv_cyc[5] - pv_cyc[4]), 64'd1);
        chk("f2_gap", 64'(pv_cyc[6] - pv_cyc[5]), 64'd4);
        chk("f2_pv_cnt", 64'(pv_cnt), 64'd16);
        chk("f2_pix", 64'(pix_bad), 64'd0);
        chk("f2_count", 64'(bus.out_count), 64'd16);

        // Frame 3: only 10 results, drain times out
        conv_limit = 10;
        start_frame();
        wait_done();
        chk("f3_tmo_done", 64'(bus.timeout_err), 64'd1);
        @(negedge clk);
        chk("f3_drain", 64'(done_cyc - rd_last), 64'd65);
        chk("f3_count", 64'(bus.out_count), 64'd10);
        chk("f3_idle", 64'(bus.busy), 64'd0);
        chk("f3_tmo_hold", 64'(bus.timeout_err), 64'd1);

        // Frame 4: restart clears, starts in STREAM/DONE ignored
        conv_limit = 16;
        fs0 = fs_total;
        start_frame();
        chk("f4_cnt_clr", 64'(bus.out_count), 64'd0);
        chk("f4_tmo_clr", 64'(bus.timeout_err), 64'd0);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("f4_done_ign", 64'(bus.busy), 64'd0);
        repeat (3) @(negedge clk);
        chk("f4_idle", 64'(bus.busy), 64'd0);
        chk("f4_fs_cnt", 64'(fs_total - fs0), 64'd1);
        chk("f4_rd_cnt", 64'(rd_cnt), 64'd16);
        chk("f4_count", 64'(bus.out_count), 64'd16);

        // Frame 5: reset while address 7 is on the bus
        start_frame();
        for (int i = 0; i < 40; i++) begin
            if (bus.mem_rd_en && bus.mem_addr == 4'd7) break;
            @(negedge clk);
        end
        chk("f5_at7", 64'(bus.mem_addr), 64'd7);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("f5_pv", 64'(bus.pixel_valid), 64'd0);
        chk("f5_rden", 64'(bus.mem_rd_en), 64'd0);
        chk("f5_busy", 64'(bus.busy), 64'd0);
        chk("f5_fs", 64'(bus.frame_start), 64'd0);
        chk("f5_done", 64'(bus.done), 64'd0);
        chk("f5_cnt", 64'(bus.out_count), 64'd0);
        chk("f5_addr", 64'(bus.mem_addr), 64'd0);
        @(negedge clk);

        // Frame 6: fresh frame after reset starts at address 0
        start_frame();
        @(negedge clk);
        chk("f6_rden", 64'(bus.mem_rd_en), 64'd1);
        chk("f6_addr0", 64'(bus.mem_addr), 64'd0);
        wait_done();
        @(negedge clk);
        chk("f6_addr", 64'(addr_bad), 64'd0);
        chk("f6_count", 64'(bus.out_count), 64'd16);

        // conv_valid while idle is ignored
        dt0 = done_total;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 idle_pulse = 1'b1;
            @(posedge clk);
            #1 idle_pulse = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("idle_count", 64'(bus.out_count), 64'd16);
        chk("idle_done", 64'(done_total - dt0), 64'd0);
        chk("idle_busy", 64'(bus.busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_frame_ctrl.md
Name: conv_frame_ctrl

Overview:
- Frame sequencer that feeds one image into the conv layer and tracks its results.
- Reads the image in raster order from a synchronous-read frame buffer and drives the conv layer's frame_start, pixel_valid and pixel input.
- Counts conv_valid results, reports completion, and flags a timeout if the expected number of outputs never arrives.
- Sits between the frame buffer and the conv instance; the host issues one start per frame.

Parameters:
- DATA_WIDTH, 8, bits per channel sample.
- IN_CHANNEL, 3, channels packed per pixel word.
- IMG_WIDTH, 4, image width in pixels.
- IMG_HEIGHT, 4, image height in pixels.
- KERNEL_SIZE, 3, conv kernel size; used only to compute the expected output count.
- STRIDE, 1, conv stride; used only to compute the expected output count.
- PADDING, (KERNEL_SIZE-1)/2, conv padding; used only to compute the expected output count.
- ADDR_WIDTH, 4, frame buffer address width; must satisfy 2^ADDR_WIDTH >= IMG_WIDTH*IMG_HEIGHT.
- CNT_WIDTH, 16, width of the output counter.
- TIMEOUT_CYCLES, 64, maximum DRAIN cycles with no completion.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- start  in  1  start-frame request; sampled only in IDLE.
- stall  in  1  downstream hold; when 1, no new read is issued.
- mem_rd_en  out  1  frame buffer read enable.
- mem_addr  out  ADDR_WIDTH  frame buffer read address.
- mem_rdata  in  IN_CHANNEL*DATA_WIDTH  read data, valid one cycle after mem_rd_en.
- frame_start  out  1  one-cycle frame start pulse to conv.
- pixel_valid  out  1  pixel strobe to conv.
- pixel_out  out  IN_CHANNEL*DATA_WIDTH  pixel to conv.
- conv_valid  in  1  result strobe from conv.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- timeout_err  out  1  sticky timeout flag; cleared on the next accepted start.
- out_count  out  CNT_WIDTH  conv_valid count for the current frame.

Behaviour:
- Reset: one clock, rst_n synchronous active-low. Reset forces state=IDLE, rd_ptr=0, pixel_valid=0, frame_start=0, done=0, timeout_err=0, out_count=0, timeout counter=0.
- Reset mid-frame discards any in-flight read; pixel_valid is 0 on the cycle after reset.
- Derived constants:
  - OUT_W = (IMG_WIDTH + 2*PADDING - KERNEL_SIZE)/STRIDE + 1
  - OUT_H = (IMG_HEIGHT + 2*PADDING - KERNEL_SIZE)/STRIDE + 1
  - N_OUT = OUT_W*OUT_H
  - N_PIX = IMG_WIDTH*IMG_HEIGHT
- FSM states: IDLE, START, STREAM, DRAIN, DONE.
- IDLE:
  - start=1 at a clock edge -> START.
  - On that same edge: rd_ptr<=0, out_count<=0, timeout_err<=0.
- START: lasts exactly one cycle; frame_start=1 during it; then -> STREAM. frame_start is 0 in all other states.
- STREAM:
  - mem_rd_en = (state==STREAM) && !stall, combinational.
  - mem_addr = rd_ptr.
  - Each cycle with mem_rd_en=1, rd_ptr increments.
  - When the read at address N_PIX-1 is issued -> DRAIN.
  - With stall=0 throughout, addresses 0..N_PIX-1 are issued in N_PIX consecutive cycles.
- Read pipeline:
  - pixel_valid is mem_rd_en registered once.
  - pixel_out = mem_rdata, passed through combinationally.
  - The first pixel_valid occurs 2 cycles after frame_start.
  - stall never cancels a read already issued; its pixel_valid still fires next cycle.
- DRAIN:
  - The timeout counter starts at 0 on DRAIN entry and increments each cycle.
  - When out_count reaches N_OUT -> DONE.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1 -> set timeout_err=1 and -> DONE.
  - If both conditions hold on the same edge, completion wins and timeout_err stays 0.
- DONE: done=1 for one cycle; then -> IDLE. busy=0 from the next cycle.
- Output counting:
  - conv_valid increments out_count in START, STREAM, DRAIN and DONE; it is ignored in IDLE.
  - out_count saturates at 2^CNT_WIDTH-1.
  - out_count holds its value in IDLE until the next accepted start.
  - Reaching N_OUT during STREAM does not end the frame early; all N_PIX reads are still issued.
- start while busy=1 is ignored, including during the DONE cycle.
- stall is ignored outside STREAM.

Test Plan:
- Default parameters, start pulse, stall=0, conv model returns 16 conv_valid:
  - frame_start is high 1 cycle.
  - mem_addr runs 0..15 on 16 consecutive cycles.
  - pixel_valid is high for 16 cycles, starting 2 cycles after frame_start.
  - done pulses once; out_count=16; timeout_err=0.
- Same frame, stall=1 for 3 cycles right after address 5 is issued:
  - Addresses stay gap-free and strictly increasing.
  - pixel_valid for address 5 still fires, followed by a 3-cycle gap.
  - Total pixel_valid = 16; out_count=16.
- Conv model returns only 10 outputs:
  - DRAIN lasts 64 cycles, then timeout_err=1 and done pulses.
  - out_count=10; busy=0 afterwards.
- Back-to-back frames and ignored starts:
  - Second start after done: out_count resets to 0 and timeout_err clears.
  - A start asserted during STREAM or DONE is ignored; no second frame_start appears.
- rst_n=0 while mem_addr=7:
  - On the next cycle all outputs are at their reset values and pixel_valid=0.
  - A following start begins at address 0.
- conv_valid pulsed 5 times while IDLE: out_count stays unchanged and no done pulse occurs.
